// File: rtl/fetch_unit_if.sv
// Handshake bundles used by the fetch stage: the instruction-memory port
// (request/response) and the decoder-facing instruction port.
interface imem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

interface fetch_out_if;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;

  modport master (output valid, instr, pc, input ready);
  modport slave  (input valid, instr, pc, output ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: in-order word fetches under a credit limit, response
// buffering with PC tagging, and redirect handling that discards stale fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  imem_if.master      imem,
  fetch_out_if.master dec
);

  localparam int unsigned   PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CW      = $clog2(FIFO_DEPTH + 1) + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d;

  logic [31:0]   instr_mem_q [FIFO_DEPTH];
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [31:0]   tag_mem_q   [FIFO_DEPTH];

  logic [CW-1:0] used;
  logic          credit;
  logic          req_fire;
  logic          resp;
  logic          push;
  logic          pop;
  logic          out_valid;

  // Everything that will eventually occupy a buffer slot counts against the credit,
  // including responses that are only coming back to be thrown away.
  assign used      = out_cnt_q + occ_q + drop_cnt_q;
  assign credit    = used < DEPTH_C;
  assign req_fire  = imem.req_valid && imem.req_ready;
  assign resp      = rst_n && imem.resp_valid;
  assign out_valid = rst_n && !redirect_valid_i && (occ_q != '0);
  assign pop       = out_valid && dec.ready;
  assign push      = resp && (drop_cnt_q == '0) && !redirect_valid_i;

  assign imem.req_valid = rst_n && !redirect_valid_i && credit;
  assign imem.req_addr  = fetch_pc_q;

  assign dec.valid = out_valid;
  assign dec.instr = out_valid ? instr_mem_q[rd_ptr_q] : NOP;
  assign dec.pc    = out_valid ? pc_mem_q[rd_ptr_q] : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(resp);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      tag_wr_d   = ptr_inc(tag_wr_q);
    end
    if (resp) begin
      tag_rd_d = ptr_inc(tag_rd_q);
    end

    // A redirect cycle's own response is discarded, so only the rest need dropping.
    if (redirect_valid_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      drop_cnt_d = out_cnt_q - CW'(resp);
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (resp && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Storage needs no reset: the occupancy and pointer registers qualify its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem.resp_data;
      pc_mem_q[wr_ptr_q]    <= tag_mem_q[tag_rd_q];
    end
    if (req_fire) begin
      tag_mem_q[tag_wr_q] <= fetch_pc_q;
    end
  end

  resp_without_request: assert property (
    @(posedge clk) disable iff (!rst_n) imem.resp_valid |-> (out_cnt_q != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-randomised memory model plus an
// expected-PC stream model that restarts at every redirect target.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  imem_if      imem_bus ();
  fetch_out_if dec_bus ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .imem            (imem_bus),
    .dec             (dec_bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_due = -1;
  int          n_req = 0;
  int          n_out = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned rdy_pct = 100;
  int unsigned ifr_pct = 100;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_req_pc;
  logic [31:0] exp_out_pc;

  logic        s_req_valid, s_req_fire, s_out_valid, s_out_fire, s_resp;
  logic [31:0] s_req_addr, s_instr, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: drive inputs just after the edge, sample at the falling edge.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc);
    int unsigned lat;
    redirect_valid     = redir;
    redirect_pc        = rpc;
    imem_bus.req_ready = ($urandom_range(99) < rdy_pct);
    dec_bus.ready      = ($urandom_range(99) < ifr_pct);
    s_resp             = 1'b0;
    imem_bus.resp_data = $urandom;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      s_resp             = 1'b1;
      imem_bus.resp_data = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    imem_bus.resp_valid = s_resp;
    #4;
    s_req_valid = imem_bus.req_valid;
    s_req_addr  = imem_bus.req_addr;
    s_req_fire  = imem_bus.req_valid && imem_bus.req_ready;
    s_out_valid = dec_bus.valid;
    s_instr     = dec_bus.instr;
    s_pc        = dec_bus.pc;
    s_out_fire  = dec_bus.valid && dec_bus.ready;
    if (s_out_valid !== 1'b1) begin
      checks++;
      if (s_instr !== NOP || s_pc !== 32'h0) begin
        errors++;
        $display("[TB] FAIL idle_outputs cyc=%0d: instr=%h pc=%h, expected instr=%h pc=0", cyc, s_instr, s_pc, NOP);
      end
    end
    if (redir) begin
      checks++;
      if (s_out_valid !== 1'b0 || s_req_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL redirect_quiet cyc=%0d: if_valid=%b req_valid=%b, expected 0 0", cyc, s_out_valid, s_req_valid);
      end
    end
    if (s_req_fire) begin
      checks++;
      if (s_req_addr !== exp_req_pc) begin
        errors++;
        $display("[TB] FAIL req_addr cyc=%0d: got %h expected %h", cyc, s_req_addr, exp_req_pc);
      end
      exp_req_pc = exp_req_pc + 32'd4;
      lat = $urandom_range(lat_max, lat_min);
      last_due = (cyc + int'(lat) > last_due) ? cyc + int'(lat) : last_due + 1;
      pend_addr.push_back(s_req_addr);
      pend_due.push_back(last_due);
      n_req++;
    end
    if (s_out_fire) begin
      checks++;
      if (s_pc !== exp_out_pc || s_instr !== mem_word(exp_out_pc)) begin
        errors++;
        $display("[TB] FAIL stream cyc=%0d: pc=%h instr=%h, expected pc=%h instr=%h", cyc, s_pc, s_instr, exp_out_pc, mem_word(exp_out_pc));
      end
      exp_out_pc = exp_out_pc + 32'd4;
      n_out++;
    end
    checks++;
    if (pend_addr.size() > DEPTH) begin
      errors++;
      $display("[TB] FAIL outstanding_cap cyc=%0d: got %0d in flight, limit %0d", cyc, pend_addr.size(), DEPTH);
    end
    if (redir) begin
      exp_req_pc = {rpc[31:2], 2'b00};
      exp_out_pc = exp_req_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset(input int n);
    rst_n               = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    imem_bus.req_ready  = 1'b1;
    imem_bus.resp_valid = 1'b0;
    imem_bus.resp_data  = 32'h0;
    dec_bus.ready       = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    pend_addr.delete();
    pend_due.delete();
    last_due   = -1;
    cyc        = 0;
    exp_req_pc = RESET_PC;
    exp_out_pc = RESET_PC;
  endtask

  task automatic test_reset();
    rst_n               = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    imem_bus.req_ready  = 1'b1;
    imem_bus.resp_valid = 1'b0;
    imem_bus.resp_data  = 32'h0;
    dec_bus.ready       = 1'b1;
    @(posedge clk);
    #5;
    checks++;
    if (imem_bus.req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_bus.req_valid);
    end
    checks++;
    if (dec_bus.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_if_valid: got %b expected 0", dec_bus.valid);
    end
    checks++;
    if (dec_bus.instr !== NOP || dec_bus.pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_if_data: instr=%h pc=%h, expected %h 0", dec_bus.instr, dec_bus.pc, NOP);
    end
    doReset(1);
  endtask

  task automatic test_basic();
    logic [31:0] seen[$];
    logic [31:0] want;
    int first_req   = -1;
    int first_valid = -1;
    lat_min = 1; lat_max = 1; rdy_pct = 100; ifr_pct = 100;
    for (int i = 0; i < 30 && seen.size() < 3; i++) begin
      applyStimulus(1'b0, 32'h0);
      if (s_req_fire && first_req < 0) first_req = cyc - 1;
      if (s_out_valid && first_valid < 0) first_valid = cyc - 1;
      if (s_out_fire) seen.push_back(s_pc);
    end
    checks++;
    if (first_req != 0) begin
      errors++;
      $display("[TB] FAIL first_request_cycle: got %0d expected 0", first_req);
    end
    checks++;
    if (first_valid < 2) begin
      errors++;
      $display("[TB] FAIL first_valid_latency: got cycle %0d expected >= 2", first_valid);
    end
    for (int i = 0; i < 3; i++) begin
      want = RESET_PC + 32'(4 * i);
      checks++;
      if (i >= seen.size()) begin
        errors++;
        $display("[TB] FAIL basic_pc_%0d: got nothing expected %h", i, want);
      end else if (seen[i] !== want) begin
        errors++;
        $display("[TB] FAIL basic_pc_%0d: got %h expected %h", i, seen[i], want);
      end
    end
  endtask

  task automatic test_backpressure();
    int req_before;
    int out_before;
    ifr_pct = 0;
    req_before = n_req;
    repeat (10) applyStimulus(1'b0, 32'h0);
    checks++;
    if (n_req - req_before > DEPTH) begin
      errors++;
      $display("[TB] FAIL stall_requests: got %0d expected <= %0d", n_req - req_before, DEPTH);
    end
    checks++;
    if (s_req_valid !== 1'b0 || s_out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_state: req_valid=%b if_valid=%b, expected 0 1", s_req_valid, s_out_valid);
    end
    ifr_pct = 100;
    out_before = n_out;
    repeat (20) applyStimulus(1'b0, 32'h0);
    checks++;
    if (n_out - out_before < 5) begin
      errors++;
      $display("[TB] FAIL stall_release: got %0d instrs expected >= 5", n_out - out_before);
    end
  endtask

  task automatic test_redirect_inflight();
    bit          hit = 1'b0;
    bit          got_req = 1'b0;
    bit          got_out = 1'b0;
    logic [31:0] first_req_addr = 32'h0;
    logic [31:0] first_out_pc = 32'h0;
    lat_min = 4; lat_max = 4; rdy_pct = 100; ifr_pct = 100;
    for (int i = 0; i < 50; i++) begin
      if (pend_addr.size() == 2 && pend_due[0] > cyc) begin
        hit = 1'b1;
        break;
      end
      applyStimulus(1'b0, 32'h0);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL redirect_setup: got %0d in flight expected 2", pend_addr.size());
    end
    applyStimulus(1'b1, 32'h0000_2002);
    for (int i = 0; i < 60 && !(got_req && got_out); i++) begin
      applyStimulus(1'b0, 32'h0);
      if (s_req_fire && !got_req) begin got_req = 1'b1; first_req_addr = s_req_addr; end
      if (s_out_fire && !got_out) begin got_out = 1'b1; first_out_pc = s_pc; end
    end
    checks++;
    if (!got_req || first_req_addr !== 32'h0000_2000) begin
      errors++;
      $display("[TB] FAIL redirect_req_addr: got %h (seen=%0d) expected 00002000", first_req_addr, got_req);
    end
    checks++;
    if (!got_out || first_out_pc !== 32'h0000_2000) begin
      errors++;
      $display("[TB] FAIL redirect_first_pc: got %h (seen=%0d) expected 00002000", first_out_pc, got_out);
    end
  endtask

  task automatic test_redirect_resp();
    bit          hit = 1'b0;
    bit          got_out = 1'b0;
    int          stale, last_stale_due, r, want_req;
    int          first_req_cyc = -1;
    logic [31:0] first_out_pc = 32'h0;
    lat_min = 3; lat_max = 3; rdy_pct = 100; ifr_pct = 100;
    for (int i = 0; i < 50; i++) begin
      if (i > 4 && pend_addr.size() >= 1 && pend_due[0] <= cyc) begin
        hit = 1'b1;
        break;
      end
      applyStimulus(1'b0, 32'h0);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL redirect_resp_setup: got no response-cycle alignment expected one");
    end
    stale          = pend_addr.size() - 1;
    last_stale_due = (stale > 0) ? pend_due[pend_due.size() - 1] : -1;
    r              = cyc;
    applyStimulus(1'b1, 32'h0000_3000);
    checks++;
    if (s_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect_resp_if_valid: got %b expected 0", s_out_valid);
    end
    for (int i = 0; i < 60 && !(got_out && first_req_cyc >= 0); i++) begin
      applyStimulus(1'b0, 32'h0);
      if (s_req_fire && first_req_cyc < 0) first_req_cyc = cyc - 1;
      if (s_out_fire && !got_out) begin got_out = 1'b1; first_out_pc = s_pc; end
    end
    // With two credits, any stale response still owed blocks new requests until it lands.
    want_req = (stale > 0) ? last_stale_due + 1 : r + 1;
    checks++;
    if (first_req_cyc != want_req) begin
      errors++;
      $display("[TB] FAIL redirect_resp_restart: got cycle %0d expected %0d", first_req_cyc, want_req);
    end
    checks++;
    if (!got_out || first_out_pc !== 32'h0000_3000) begin
      errors++;
      $display("[TB] FAIL redirect_resp_first_pc: got %h (seen=%0d) expected 00003000", first_out_pc, got_out);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    lat_min = 1; lat_max = 2; rdy_pct = 100; ifr_pct = 100;
    applyStimulus(1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 30 && addrs.size() < 2; i++) begin
      applyStimulus(1'b0, 32'h0);
      if (s_req_fire) addrs.push_back(s_req_addr);
    end
    checks++;
    if (addrs.size() < 1 || addrs[0] !== 32'hFFFF_FFFC) begin
      errors++;
      $display("[TB] FAIL wrap_first: got %0d addrs expected first FFFFFFFC", addrs.size());
    end
    checks++;
    if (addrs.size() < 2 || addrs[1] !== 32'h0000_0000) begin
      errors++;
      $display("[TB] FAIL wrap_next: got %0d addrs (last %h) expected 00000000", addrs.size(), (addrs.size() > 0) ? addrs[addrs.size() - 1] : 32'h0);
    end
    repeat (15) applyStimulus(1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    lat_min = 3; lat_max = 3; rdy_pct = 100; ifr_pct = 100;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 32'h0);
      if (i > 5 && pend_addr.size() > 0) break;
    end
    doReset(1);
    applyStimulus(1'b0, 32'h0);
    checks++;
    if (s_out_valid !== 1'b0 || s_instr !== NOP) begin
      errors++;
      $display("[TB] FAIL reset_mid_if: if_valid=%b instr=%h, expected 0 %h", s_out_valid, s_instr, NOP);
    end
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL reset_mid_req: req_valid=%b addr=%h, expected 1 %h", s_req_valid, s_req_addr, RESET_PC);
    end
    repeat (20) applyStimulus(1'b0, 32'h0);
  endtask

  task automatic test_random();
    int out_before;
    lat_min = 1; lat_max = 4; rdy_pct = 70; ifr_pct = 60;
    out_before = n_out;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(99) < 3, $urandom);
    end
    rdy_pct = 100; ifr_pct = 100;
    repeat (30) applyStimulus(1'b0, 32'h0);
    checks++;
    if (n_out - out_before < 50) begin
      errors++;
      $display("[TB] FAIL random_progress: got %0d instrs expected >= 50", n_out - out_before);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_resp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
